// File: rtl/riscv_pipe_sched.sv
// Pipeline sequencing controller: merges branch flush, load-use stall and MDU occupancy
// into per-stage write enables and flushes. Optional perf counters under RISCV_PIPE_PERF_EN.
module riscv_pipe_sched #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned MDU_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_taken_i,
  input  logic        load_use_i,
  input  logic        mdu_start_i,
  input  logic        mdu_done_i,
  output logic        pc_sel_o,
  output logic        pc_we_o,
  output logic        ifid_we_o,
  output logic        idex_we_o,
  output logic        exmem_we_o,
  output logic        ifid_flush_o,
  output logic        idex_flush_o,
  output logic        exmem_flush_o,
  output logic        mdu_kill_o,
  output logic        mdu_err_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned TW = $clog2(MDU_TIMEOUT);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_MDU_WAIT} state_t;

  state_t          state, state_nxt;
  logic [HW-1:0]   hold_cnt;
  logic [TW-1:0]   wait_cnt;
  logic            branch_act;
  logic            timeout;

  always_comb begin
    state_nxt     = state;
    pc_sel_o      = 1'b0;
    pc_we_o       = 1'b1;
    ifid_we_o     = 1'b1;
    idex_we_o     = 1'b1;
    exmem_we_o    = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    mdu_kill_o    = 1'b0;
    branch_act    = 1'b0;
    timeout       = 1'b0;
    case (state)
      S_HOLD: begin
        pc_we_o       = 1'b0;
        ifid_flush_o  = 1'b1;
        idex_flush_o  = 1'b1;
        exmem_flush_o = 1'b1;
        if (hold_cnt == HW'(HOLD_CYCLES - 1)) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (branch_taken_i) begin
          branch_act    = 1'b1;
          pc_sel_o      = 1'b1;
          ifid_flush_o  = 1'b1;
          idex_flush_o  = 1'b1;
          exmem_flush_o = 1'b1;
        end else if (mdu_start_i) begin
          // a same-cycle done means a single-cycle result: no stall at all
          if (!mdu_done_i) begin
            pc_we_o       = 1'b0;
            ifid_we_o     = 1'b0;
            idex_we_o     = 1'b0;
            exmem_flush_o = 1'b1;
            state_nxt     = S_MDU_WAIT;
          end
        end else if (load_use_i) begin
          pc_we_o      = 1'b0;
          ifid_we_o    = 1'b0;
          idex_flush_o = 1'b1;
        end
      end
      S_MDU_WAIT: begin
        if (branch_taken_i) begin
          branch_act    = 1'b1;
          pc_sel_o      = 1'b1;
          ifid_flush_o  = 1'b1;
          idex_flush_o  = 1'b1;
          exmem_flush_o = 1'b1;
          mdu_kill_o    = 1'b1;
          state_nxt     = S_RUN;
        end else if (mdu_done_i) begin
          state_nxt = S_RUN;
        end else begin
          pc_we_o       = 1'b0;
          ifid_we_o     = 1'b0;
          idex_we_o     = 1'b0;
          exmem_flush_o = 1'b1;
          if (wait_cnt == TW'(MDU_TIMEOUT - 1)) begin
            timeout    = 1'b1;
            mdu_kill_o = 1'b1;
            state_nxt  = S_RUN;
          end
        end
      end
      default: state_nxt = S_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_HOLD;
      hold_cnt  <= '0;
      wait_cnt  <= '0;
      mdu_err_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= (state == S_HOLD) ? hold_cnt + 1'b1 : '0;
      // cleared whenever not waiting, so each MDU_WAIT entry starts from zero
      wait_cnt  <= (state == S_MDU_WAIT) ? wait_cnt + 1'b1 : '0;
      mdu_err_o <= mdu_err_o | timeout;
    end
  end

`ifdef RISCV_PIPE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (state != S_HOLD && !pc_we_o) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (branch_act)                  flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_riscv_pipe_sched.sv
// Self-checking bench for riscv_pipe_sched: directed scenarios then random stimulus
// against a cycle-level behavioural model of the schedule rules.
module tb_riscv_pipe_sched;

  localparam int unsigned HOLD = 2;
  localparam int unsigned TO   = 8;

  // expected vector order: {pc_sel, pc_we, ifid_we, idex_we, exmem_we, ifid_fl, idex_fl, exmem_fl, kill}
  localparam logic [8:0] P_HOLD   = 9'b001111110;
  localparam logic [8:0] P_NORM   = 9'b011110000;
  localparam logic [8:0] P_BRANCH = 9'b111111110;
  localparam logic [8:0] P_STALL  = 9'b000010010;
  localparam logic [8:0] P_LOADU  = 9'b000110100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic branch_taken_i = 1'b0, load_use_i = 1'b0, mdu_start_i = 1'b0, mdu_done_i = 1'b0;
  logic pc_sel_o, pc_we_o, ifid_we_o, idex_we_o, exmem_we_o;
  logic ifid_flush_o, idex_flush_o, exmem_flush_o, mdu_kill_o, mdu_err_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  int          hold_left = HOLD;
  bit          busy      = 1'b0;
  int          waited    = 0;
  bit          err_m     = 1'b0;
  logic [31:0] stalls_m  = '0;
  logic [31:0] flushes_m = '0;

  riscv_pipe_sched #(.HOLD_CYCLES(HOLD), .MDU_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .branch_taken_i(branch_taken_i), .load_use_i(load_use_i),
    .mdu_start_i(mdu_start_i), .mdu_done_i(mdu_done_i),
    .pc_sel_o(pc_sel_o), .pc_we_o(pc_we_o), .ifid_we_o(ifid_we_o),
    .idex_we_o(idex_we_o), .exmem_we_o(exmem_we_o),
    .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o), .exmem_flush_o(exmem_flush_o),
    .mdu_kill_o(mdu_kill_o), .mdu_err_o(mdu_err_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // one clock cycle: drive at negedge, compare after settling, advance model at posedge
  task automatic step(input bit r, input bit bt, input bit lu, input bit ms, input bit md);
    logic [8:0]  e;
    logic [8:0]  got;
    int          n_hold;
    bit          n_busy, n_err, holding;
    int          n_waited;
    logic [31:0] n_st, n_fl;
    @(negedge clk);
    rst_n = r; branch_taken_i = bt; load_use_i = lu; mdu_start_i = ms; mdu_done_i = md;
    #1;
    if (!r) begin
      hold_left = HOLD; busy = 1'b0; waited = 0; err_m = 1'b0;
      stalls_m = '0; flushes_m = '0;
    end
    n_hold = hold_left; n_busy = busy; n_waited = waited; n_err = err_m;
    n_st = stalls_m; n_fl = flushes_m;
    holding = !r || hold_left > 0;
    if (holding) begin
      e = P_HOLD;
      if (r) n_hold = hold_left - 1;
    end else if (busy) begin
      if (bt) begin
        e = P_BRANCH | 9'd1; n_busy = 1'b0; n_fl = flushes_m + 1;
      end else if (md) begin
        e = P_NORM; n_busy = 1'b0;
      end else begin
        e = P_STALL;
        if (waited == TO - 1) begin
          e = e | 9'd1; n_err = 1'b1; n_busy = 1'b0;
        end else n_waited = waited + 1;
      end
    end else begin
      if (bt) begin
        e = P_BRANCH; n_fl = flushes_m + 1;
      end else if (ms && !md) begin
        e = P_STALL; n_busy = 1'b1; n_waited = 0;
      end else if (ms) e = P_NORM;
      else if (lu)     e = P_LOADU;
      else             e = P_NORM;
    end
    if (!holding && !e[7]) n_st = stalls_m + 1;

    got = {pc_sel_o, pc_we_o, ifid_we_o, idex_we_o, exmem_we_o,
           ifid_flush_o, idex_flush_o, exmem_flush_o, mdu_kill_o};
    check("stage_ctl", 32'(got), 32'(e));
    check("mdu_err", 32'(mdu_err_o), 32'(err_m));
`ifdef RISCV_PIPE_PERF_EN
    check("stall_cnt", stall_cnt_o, stalls_m);
    check("flush_cnt", flush_cnt_o, flushes_m);
`else
    check("stall_cnt", stall_cnt_o, 32'd0);
    check("flush_cnt", flush_cnt_o, 32'd0);
`endif
    @(posedge clk);
    if (r) begin
      hold_left = n_hold; busy = n_busy; waited = n_waited; err_m = n_err;
      stalls_m = n_st; flushes_m = n_fl;
    end
  endtask

  initial begin
    // reset, purge, then normal
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0);
    step(1, 1, 1, 1, 1);
    step(1, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    // single load-use bubble
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    // MDU with done four cycles after start
    step(1, 0, 0, 1, 0);
    repeat (3) step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    // single-cycle MDU result
    step(1, 0, 0, 1, 1);
    // branch and done collide in MDU_WAIT
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    // timeout without done, error stays set
    step(1, 0, 0, 1, 0);
    repeat (TO) step(1, 0, 0, 0, 0);
    repeat (3) step(1, 0, 1, 0, 0);
    // all three hazard sources in one RUN cycle
    step(1, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    // mid-operation reset clears error
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 4) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
